// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encoding and default pattern/gap for the serial pattern transmitter
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_e;

  localparam logic [3:0] DEF_PATTERN = 4'b1101;
  localparam int         DEF_GAP     = 1;

endpackage

// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - shifts a captured pattern out MSB-first, repeated with idle gaps
module seq_tx
  import seq_pkg::*;
#(
  parameter int PAT_LEN = $bits(DEF_PATTERN),
  parameter int REP_W   = 4,
  parameter int GAP_LEN = DEF_GAP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [REP_W-1:0]   reps,
  input  logic               abort,
  output logic               ready,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  localparam int              BW       = $clog2(PAT_LEN);
  localparam logic [BW-1:0]   MSB_IDX  = BW'(PAT_LEN - 1);
  localparam logic [3:0]      GAP_LAST = 4'(GAP_LEN - 1);

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [BW-1:0]      bit_nxt;
  logic [3:0]         gap_q, gap_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               out_q, out_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    rep_d   = rep_q;
    out_d   = 1'b0;
    vld_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bit_nxt = bit_q - BW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (reps != '0) begin
            state_d = SHIFT;
            pat_d   = pattern;
            rep_d   = reps;
            bit_d   = MSB_IDX;
            out_d   = pattern[PAT_LEN-1];
            vld_d   = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_q != '0) begin
          bit_d  = bit_nxt;
          out_d  = pat_q[bit_nxt];
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end else if (rep_q > REP_W'(1)) begin
          busy_d = 1'b1;
          if (GAP_LEN > 0) begin
            state_d = GAP;
            gap_d   = GAP_LAST;
          end else begin
            // back-to-back: the next repetition's MSB follows the LSB directly
            rep_d = rep_q - REP_W'(1);
            bit_d = MSB_IDX;
            out_d = pat_q[PAT_LEN-1];
            vld_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          if (gap_q == 4'd0) begin
            state_d = SHIFT;
            rep_d   = rep_q - REP_W'(1);
            bit_d   = MSB_IDX;
            out_d   = pat_q[PAT_LEN-1];
            vld_d   = 1'b1;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        bit_d   = '0;
        gap_d   = '0;
        rep_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign out       = out_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// tb/tb_seq_tx.sv - directed self-checking bench for seq_tx
module tb_seq_tx;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] reps;
  logic       abort;
  logic       ready;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_bad;

  seq_tx #(.PAT_LEN(4), .REP_W(4), .GAP_LEN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pattern   (pattern),
    .reps      (reps),
    .abort     (abort),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // status vector layout: {ready, out, out_valid, busy, done}

  task automatic test_reset();
    logic [4:0] st;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = 4'b0000;
    reps    = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    st = {ready, out, out_valid, busy, done};
    n_cmp++;
    if (st !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset got %b want %b", st, 5'b10000);
    end
  endtask

  task automatic test_single();
    logic [4:0] exp_tab [1:6];
    logic [4:0] st;
    exp_tab[1] = 5'b01110;
    exp_tab[2] = 5'b01110;
    exp_tab[3] = 5'b00110;
    exp_tab[4] = 5'b01110;
    exp_tab[5] = 5'b10001;
    exp_tab[6] = 5'b10000;
    start = 1'b1; pattern = 4'b1101; reps = 4'd1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      st = {ready, out, out_valid, busy, done};
      n_cmp++;
      if (st !== exp_tab[k]) begin
        n_bad++;
        $display("FAIL single k=%0d got %b want %b", k, st, exp_tab[k]);
      end
    end
  endtask

  task automatic test_repeat_gap();
    logic [13:0] bits;
    logic [13:0] vlds;
    logic [4:0]  st;
    logic [4:0]  exp_st;
    logic [3:0]  sh;
    int          det;
    bits = 14'b11010110101101;
    vlds = 14'b11110111101111;
    sh   = 4'b0000;
    det  = 0;
    start = 1'b1; pattern = 4'b1101; reps = 4'd3;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      st = {ready, out, out_valid, busy, done};
      if (k < 14) exp_st = {1'b0, bits[13-k], vlds[13-k], 1'b1, 1'b0};
      else if (k == 14) exp_st = 5'b10001;
      else exp_st = 5'b10000;
      n_cmp++;
      if (st !== exp_st) begin
        n_bad++;
        $display("FAIL repeat k=%0d got %b want %b", k + 1, st, exp_st);
      end
      if (k < 14) begin
        if ({sh[2:0], out} == 4'b1101) begin
          det++;
          sh = 4'b0000;
        end else begin
          sh = {sh[2:0], out};
        end
      end
    end
    n_cmp++;
    if (det != 3) begin
      n_bad++;
      $display("FAIL detections got %0d want 3", det);
    end
  endtask

  task automatic test_zero_and_busy_start();
    logic [8:0] bits;
    logic [8:0] vlds;
    logic [4:0] st;
    logic [4:0] exp_st;
    start = 1'b1; pattern = 4'b1011; reps = 4'd0;
    @(negedge clk);
    start = 1'b0;
    st = {ready, out, out_valid, busy, done};
    n_cmp++;
    if (st !== 5'b10001) begin
      n_bad++;
      $display("FAIL zero_reps k=1 got %b want %b", st, 5'b10001);
    end
    @(negedge clk);
    st = {ready, out, out_valid, busy, done};
    n_cmp++;
    if (st !== 5'b10000) begin
      n_bad++;
      $display("FAIL zero_reps k=2 got %b want %b", st, 5'b10000);
    end

    bits = 9'b100101001;
    vlds = 9'b111101111;
    start = 1'b1; pattern = 4'b1001; reps = 4'd2;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) begin
        start = 1'b1; pattern = 4'b1111; reps = 4'd5;
      end
      st = {ready, out, out_valid, busy, done};
      if (k < 9) exp_st = {1'b0, bits[8-k], vlds[8-k], 1'b1, 1'b0};
      else if (k == 9) exp_st = 5'b10001;
      else exp_st = 5'b10000;
      n_cmp++;
      if (st !== exp_st) begin
        n_bad++;
        $display("FAIL busy_start k=%0d got %b want %b", k + 1, st, exp_st);
      end
    end
  endtask

  task automatic test_abort();
    logic [4:0] exp_tab [1:8];
    logic [4:0] st;
    exp_tab[1] = 5'b01110;
    exp_tab[2] = 5'b01110;
    exp_tab[3] = 5'b00110;
    exp_tab[4] = 5'b10000;
    exp_tab[5] = 5'b10000;
    exp_tab[6] = 5'b10000;
    exp_tab[7] = 5'b10000;
    exp_tab[8] = 5'b10000;
    start = 1'b1; pattern = 4'b1101; reps = 4'd2;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 3);
      st = {ready, out, out_valid, busy, done};
      n_cmp++;
      if (st !== exp_tab[k]) begin
        n_bad++;
        $display("FAIL abort k=%0d got %b want %b", k, st, exp_tab[k]);
      end
    end

    start = 1'b1; abort = 1'b1; pattern = 4'b1101; reps = 4'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    st = {ready, out, out_valid, busy, done};
    n_cmp++;
    if (st !== 5'b01110) begin
      n_bad++;
      $display("FAIL start_over_abort got %b want %b", st, 5'b01110);
    end
    repeat (4) @(negedge clk);
    st = {ready, out, out_valid, busy, done};
    n_cmp++;
    if (st !== 5'b10001) begin
      n_bad++;
      $display("FAIL start_over_abort_done got %b want %b", st, 5'b10001);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] pre [1:5];
    logic [4:0] post [1:6];
    logic [4:0] st;
    pre[1] = 5'b01110;
    pre[2] = 5'b01110;
    pre[3] = 5'b00110;
    pre[4] = 5'b01110;
    pre[5] = 5'b00010;
    post[1] = 5'b01110;
    post[2] = 5'b01110;
    post[3] = 5'b00110;
    post[4] = 5'b01110;
    post[5] = 5'b10001;
    post[6] = 5'b10000;
    @(negedge clk);
    start = 1'b1; pattern = 4'b1101; reps = 4'd2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      st = {ready, out, out_valid, busy, done};
      n_cmp++;
      if (st !== pre[k]) begin
        n_bad++;
        $display("FAIL reset_mid_pre k=%0d got %b want %b", k, st, pre[k]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    st = {ready, out, out_valid, busy, done};
    n_cmp++;
    if (st !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_mid_async got %b want %b", st, 5'b10000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; pattern = 4'b1101; reps = 4'd1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      st = {ready, out, out_valid, busy, done};
      n_cmp++;
      if (st !== post[k]) begin
        n_bad++;
        $display("FAIL reset_mid_post k=%0d got %b want %b", k, st, post[k]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_repeat_gap();
    test_zero_and_busy_start();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
